// File: rtl/sprite_pkg.sv
// Shared types and helpers for the animated sprite-frame selector.
package sprite_pkg;
  typedef enum logic {STAND = 1'b0, WALK = 1'b1} state_t;

  localparam logic DIR_BACK  = 1'b0;
  localparam logic DIR_FRONT = 1'b1;

  // Flattened slot number for a direction and frame (0 = stand, 1..n_walk = walk).
  function automatic int unsigned slot_index(input logic dir, input int unsigned f,
                                             input int unsigned n_walk);
    return (dir ? (n_walk + 1) : 0) + f;
  endfunction
endpackage

// File: rtl/sprite_anim_seq.sv
// Walk-cycle sequencer: stand/walk FSM, frame hold counter, walk index and
// tick-latched direction, reduced to the slot index that drives the pixel mux.
module anim_seq
  import sprite_pkg::*;
#(
  parameter int N_WALK          = 3,
  parameter int TICKS_PER_FRAME = 6,
  parameter int SEL_W           = $clog2(2*(N_WALK+1))
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             walk,
  input  logic             face_front,
  output logic [SEL_W-1:0] frame_sel,
  output logic             dir_q
);
  localparam int IDX_W = $clog2(N_WALK+1);
  localparam int CNT_W = $clog2(TICKS_PER_FRAME) + 1;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;
  int unsigned      w_f;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STAND;
      r_idx   <= IDX_W'(1);
      r_cnt   <= '0;
      r_dir   <= DIR_BACK;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    if (tick) begin
      w_dir_nxt = face_front;
      case (r_state)
        STAND: if (walk) begin
          w_state_nxt = WALK;
          w_idx_nxt   = IDX_W'(1);
          w_cnt_nxt   = '0;
        end
        WALK: if (!walk) begin
          w_state_nxt = STAND;
          w_idx_nxt   = IDX_W'(1);
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(TICKS_PER_FRAME-1)) begin
          // Frame hold expired: advance, wrapping back to the first walk frame.
          w_cnt_nxt = '0;
          w_idx_nxt = (r_idx == IDX_W'(N_WALK)) ? IDX_W'(1) : r_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        default: w_state_nxt = STAND;
      endcase
    end
  end

  always_comb begin
    w_f = (r_state == WALK) ? int'(r_idx) : 0;
  end

  assign frame_sel = SEL_W'(slot_index(r_dir, w_f, N_WALK));
  assign dir_q     = r_dir;
endmodule

// File: rtl/sprite_anim_mux.sv
// Animated sprite-frame selector with registered pixel output.
// Optional ANIM_FREEZE_EN adds a freeze input that masks the animation tick.
module sprite_anim_mux
  import sprite_pkg::*;
#(
  parameter int PIX_W           = 8,
  parameter int N_WALK          = 3,
  parameter int TICKS_PER_FRAME = 6,
  localparam int N_SLOT         = 2*(N_WALK+1),
  localparam int SEL_W          = $clog2(N_SLOT)
) (
  input  logic                    clk25,
  input  logic                    rst_n,
`ifdef ANIM_FREEZE_EN
  input  logic                    freeze,
`endif
  input  logic                    tick,
  input  logic                    walk,
  input  logic                    face_front,
  input  logic [N_SLOT*PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0]        pix_out,
  output logic [SEL_W-1:0]        frame_sel,
  output logic                    dir_q
);
  logic             w_tick;
  logic [SEL_W-1:0] w_sel;

`ifdef ANIM_FREEZE_EN
  assign w_tick = tick & ~freeze;
`else
  assign w_tick = tick;
`endif

  anim_seq #(
    .N_WALK          (N_WALK),
    .TICKS_PER_FRAME (TICKS_PER_FRAME),
    .SEL_W           (SEL_W)
  ) u_seq (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .tick       (w_tick),
    .walk       (walk),
    .face_front (face_front),
    .frame_sel  (w_sel),
    .dir_q      (dir_q)
  );

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) pix_out <= '0;
    else        pix_out <= pix_in[w_sel*PIX_W +: PIX_W];
  end

  assign frame_sel = w_sel;
endmodule

// File: tb/tb_sprite_anim_mux.sv
// Bench for sprite_anim_mux: vector table, hand sequences and a randomized run
// against a tick-count model of the walk cycle.
module tb_sprite_anim_mux;
  localparam int PIX_W = 8, NW = 3, TPF = 6;
  localparam int NS = 2*(NW+1);

  logic clk25 = 0, rst_n = 0, tick = 0, walk = 0, face_front = 0;
  logic [NS*PIX_W-1:0] pix_in = '0;
  logic [PIX_W-1:0] pix_out;
  logic [2:0] frame_sel;
  logic dir_q;
`ifdef ANIM_FREEZE_EN
  logic freeze = 0;
`endif

  sprite_anim_mux #(.PIX_W(PIX_W), .N_WALK(NW), .TICKS_PER_FRAME(TPF)) dut (
    .clk25(clk25), .rst_n(rst_n),
`ifdef ANIM_FREEZE_EN
    .freeze(freeze),
`endif
    .tick(tick), .walk(walk), .face_front(face_front), .pix_in(pix_in),
    .pix_out(pix_out), .frame_sel(frame_sel), .dir_q(dir_q));

  always #20 clk25 = ~clk25;

  int n_vec = 0, n_err = 0;

  // Model: walking flag, count of ticks spent walking, latched direction.
  bit m_walking = 0, m_dir = 0;
  int m_wticks = 0;

  function automatic int m_sel();
    int f;
    f = m_walking ? ((m_wticks / TPF) % NW) + 1 : 0;
    return (m_dir ? NW + 1 : 0) + f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_walking = 0; m_dir = 0; m_wticks = 0;
  endtask

  task automatic model_tick(input bit w, input bit ff);
    m_dir = ff;
    if (!m_walking) begin
      if (w) begin m_walking = 1; m_wticks = 0; end
    end else if (!w) m_walking = 0;
    else m_wticks++;
  endtask

  // Called at a falling edge; drives inputs, clocks once, compares at next fall.
  task automatic cycle(input bit t, input bit w, input bit ff, input bit frz,
                       input logic [NS*PIX_W-1:0] px);
    int exp_pix;
    tick = t; walk = w; face_front = ff; pix_in = px;
`ifdef ANIM_FREEZE_EN
    freeze = frz;
`endif
    exp_pix = int'(px[m_sel()*PIX_W +: PIX_W]);
`ifdef ANIM_FREEZE_EN
    if (t && !frz) model_tick(w, ff);
`else
    if (t) model_tick(w, ff);
`endif
    @(posedge clk25);
    @(negedge clk25);
    check("frame_sel", int'(frame_sel), m_sel());
    check("pix_out", int'(pix_out), exp_pix);
    check("dir_q", int'(dir_q), int'(m_dir));
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1;
    check("rst_frame_sel", int'(frame_sel), 0);
    check("rst_pix_out", int'(pix_out), 0);
    check("rst_dir_q", int'(dir_q), 0);
    model_reset();
    @(negedge clk25);
    rst_n = 1;
  endtask

  typedef struct { bit t; bit w; bit ff; int exp_sel; } vec_t;
  vec_t tbl[$];
  logic [NS*PIX_W-1:0] fixed_px;

  initial begin
    for (int k = 0; k < NS; k++) fixed_px[k*PIX_W +: PIX_W] = PIX_W'(8'hA0 + k);

    // Reset state while held low.
    pix_in = fixed_px;
    #5;
    check("reset_pix_out", int'(pix_out), 0);
    check("reset_frame_sel", int'(frame_sel), 0);
    @(negedge clk25); @(negedge clk25);
    rst_n = 1;

    // Idle: 5 ticks standing; slot 0 = A0 reaches pix_out.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, fixed_px);
      check("idle_sel", int'(frame_sel), 0);
      check("idle_pix", int'(pix_out), 8'hA0);
    end

    // Table of hand-derived selections.
    tbl = '{'{0,0,0,0}, '{1,1,0,1}, '{0,0,1,1},
            '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1}, '{1,1,0,1},
            '{1,1,0,2}, '{1,1,1,6}, '{1,0,1,4}, '{1,1,1,5}, '{1,1,0,1}};
    foreach (tbl[i]) begin
      cycle(tbl[i].t, tbl[i].w, tbl[i].ff, 0, fixed_px);
      check($sformatf("tbl%0d_sel", i), int'(frame_sel), tbl[i].exp_sel);
    end

    // Walk cycle from a fresh stand: 25 ticks, 1x6 2x6 3x6 1x6 1.
    async_reset();
    for (int i = 0; i < 25; i++) begin
      cycle(1, 1, 0, 0, fixed_px);
      check("walk_cycle", int'(frame_sel), ((i / TPF) % NW) + 1);
    end

    // Direction switch at walk_idx 2 / tick_cnt 3, then stop and restart.
    async_reset();
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, fixed_px);
    check("pre_switch", int'(frame_sel), 2);
    cycle(1, 1, 1, 0, fixed_px); check("switch_t4", int'(frame_sel), 6);
    cycle(1, 1, 1, 0, fixed_px); check("switch_t5", int'(frame_sel), 6);
    cycle(1, 1, 1, 0, fixed_px); check("switch_adv", int'(frame_sel), 7);
    cycle(0, 0, 1, 0, fixed_px); check("between_tick", int'(frame_sel), 7);
    cycle(1, 0, 1, 0, fixed_px); check("stop", int'(frame_sel), 4);
    for (int i = 0; i < TPF; i++) begin
      cycle(1, 1, 1, 0, fixed_px); check("restart_hold", int'(frame_sel), 5);
    end
    cycle(1, 1, 1, 0, fixed_px); check("restart_adv", int'(frame_sel), 6);

    // Reset mid-walk, then first walking tick gives slot 1.
    async_reset();
    cycle(1, 1, 0, 0, fixed_px); check("post_reset_walk", int'(frame_sel), 1);

`ifdef ANIM_FREEZE_EN
    // Freeze 10 ticks at frame_sel 2 (tick_cnt 1), then hold count resumes.
    async_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, fixed_px);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 1, 1, fixed_px); check("freeze_hold", int'(frame_sel), 2);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, fixed_px); check("freeze_resume", int'(frame_sel), 2);
    end
    cycle(1, 1, 0, 0, fixed_px); check("freeze_adv", int'(frame_sel), 3);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [NS*PIX_W-1:0] px;
      for (int k = 0; k < NS; k++) px[k*PIX_W +: PIX_W] = PIX_W'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
            1'($urandom), $urandom_range(0, 7) == 0, px);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sprite_anim_mux.md
Name: sprite_anim_mux

Overview:
- Parametrised, animated sprite-frame selector; successor to the fixed 4-way stand/walk pixel selector.
- Holds 2 facing directions × (1 stand + N_WALK walk) frames, sequences the walk cycle on a frame-rate tick and latches direction at tick boundaries.
- Output pixel is registered.
- Sits between the sprite ROMs and the VGA pixel pipeline in the 25 MHz pixel domain.

Parameters:
- PIX_W, 8, pixel/colour word width.
- N_WALK, 3, walk frames per direction (≥1).
- TICKS_PER_FRAME, 6, ticks each walk frame is held (≥1).

Ports:
- clk25  in  1  pixel clock, 25 MHz; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle animation strobe (vsync-derived).
- walk  in  1  1 = character moving.
- face_front  in  1  requested direction: 0 = back, 1 = front.
- pix_in  in  2*(N_WALK+1)*PIX_W  flattened frame pixels; slot k = pix_in[k*PIX_W +: PIX_W], k = dir*(N_WALK+1)+f, f = 0 stand, 1..N_WALK walk.
- pix_out  out  PIX_W  registered selected pixel.
- frame_sel  out  $clog2(2*(N_WALK+1))  slot index currently driving pix_out.
- dir_q  out  1  latched direction.

Behaviour:
- Reset (async assert, sync release):
  - state = STAND, walk_idx = 1, tick_cnt = 0, dir_q = 0.
  - frame_sel = 0, pix_out = 0.
- Only state changes on cycles with tick = 1 (non-tick cycles hold all state); pix_out updates every cycle.
- dir_q <= face_front on every tick, regardless of state.
- State machine:
  - STAND:
    - tick & walk → WALK, walk_idx = 1, tick_cnt = 0.
    - tick & !walk → stay.
  - WALK:
    - tick & !walk → STAND, tick_cnt = 0, walk_idx = 1.
    - tick & walk & tick_cnt < TICKS_PER_FRAME-1 → tick_cnt++.
    - tick & walk & tick_cnt == TICKS_PER_FRAME-1 → tick_cnt = 0, walk_idx advances; walk_idx wraps N_WALK → 1 (never 0).
- Selection:
  - f = (state == WALK) ? walk_idx : 0.
  - sel = dir_q*(N_WALK+1) + f.
  - frame_sel and sel are a combinational function of registered state.
- Latency:
  - pix_out <= pix_in slot[sel] each clk25.
  - pix_out lags pix_in by 1 cycle.
  - A tick-induced frame change appears on pix_out 2 cycles after the tick edge (state update, then pixel register).
- Boundaries:
  - N_WALK = 1: walk_idx stays 1.
  - TICKS_PER_FRAME = 1: walk_idx advances every tick.
  - Direction change while walking keeps walk_idx and tick_cnt (phase preserved).
  - walk toggling between ticks is ignored.
  - Reset mid-walk returns to back-stand (slot 0) immediately; pix_out is forced to 0 asynchronously.
- Widths:
  - tick_cnt is $clog2(TICKS_PER_FRAME)+1 bits.
  - walk_idx is $clog2(N_WALK+1) bits.
  - No overflow is reachable.

Optional Feature:
- Macro ANIM_FREEZE_EN adds input port freeze (1 bit).
- Defined: while freeze = 1, tick is masked, so state, walk_idx, tick_cnt and dir_q hold; pix_out still tracks pix_in for the held slot.
- Undefined: no freeze port; tick is always honoured.

Decomposition:
- Shared package sprite_pkg holds:
  - state enum (STAND = 0, WALK = 1);
  - DIR_BACK = 0 and DIR_FRONT = 1;
  - a function slot_index(dir, f, n_walk).
- One natural sub-module: anim_seq (FSM, tick_cnt, walk_idx, dir_q → frame_sel).
- The top instantiates anim_seq plus the registered slice mux.

Test Plan:
- Reset then idle: rst_n low; pix_out = 0 and frame_sel = 0. After release with walk = 0 and 5 ticks, frame_sel stays 0; with slot 0 = 8'hA0, pix_out = 8'hA0 one cycle later.
- Walk cycle (defaults): walk = 1, face_front = 0, 25 ticks → frame_sel sequence 1 ×6, 2 ×6, 3 ×6, 1 ×6, … with no 0 after the first tick.
- Direction switch mid-walk: at walk_idx = 2, tick_cnt = 3, set face_front = 1 → next tick gives frame_sel = 6. walk_idx advances after 2 more ticks (4th and 5th ticks in frame).
- Stop: walk = 0 while at frame_sel = 7 (front, walk 3) → next tick gives frame_sel = 4. walk = 1 again → restarts at 5 with a full 6-tick hold.
- Reset mid-walk: assert rst_n low asynchronously between edges → pix_out = 0 and frame_sel = 0 immediately. After release, the first walking tick yields frame_sel = 1.
- ANIM_FREEZE_EN build: freeze = 1 for 10 ticks while walking at frame_sel = 2 → frame_sel stays 2 and tick_cnt is unchanged. After freeze = 0, the hold count resumes from the held value.
